data_basic_gates: RTL and testbench
===================================

// Module: data_basic_gates
// PURPOSE
//  Registered bank of the seven basic two-input logic functions (AND, OR, NAND, NOR,
//  NOT, XOR, XNOR) applied bitwise to operands a and b.
//  Serves as a reference/primitive logic unit for datapath glue and for bring-up benches.
//  All results are captured on one clock edge, so every output has one cycle of latency.
// PARAMETERS
//  WIDTH  1  Bit width of operands a, b and of every result output (>=1).
// PORTS
//  clk       in   1      Single system clock; all state updates on rising edge.
//  rst_n     in   1      Reset, synchronous, active-low; sampled on rising clk edge.
//  a         in   WIDTH  Operand A.
//  b         in   WIDTH  Operand B.
//  in_valid  in   1      Qualifies a/b this cycle.
//  out_and   out  WIDTH  a & b (registered).
//  out_or    out  WIDTH  a | b (registered).
//  out_nand  out  WIDTH  ~(a & b) (registered).
//  out_nor   out  WIDTH  ~(a | b) (registered).
//  out_not   out  WIDTH  ~a (registered; b unused for this output).
//  out_xor   out  WIDTH  a ^ b (registered).
//  out_xnor  out  WIDTH  ~(a ^ b) (registered).
//  out_valid out  1      High the cycle after in_valid was sampled high.
// BEHAVIOUR
//  - One clock domain (clk); reset is synchronous and active-low (rst_n). No async paths.
//  - Reset: while rst_n=0 at a rising edge, all seven result outputs and out_valid are
//    cleared to 0 (all-zero vector), regardless of a, b, in_valid.
//  - Reset has priority over capture. Reset asserted mid-stream discards the in-flight result.
//  - Normal operation (rst_n=1): on each rising edge with in_valid=1, all seven results are
//    computed bitwise from the a/b sampled at that edge and registered.
//    out_valid<=1.
//  - in_valid=0 at an edge: result registers hold their previous values; out_valid<=0.
//  - Latency exactly 1 cycle: values sampled at edge N are visible after edge N.
//    Back-to-back in_valid gives one new result per cycle (full throughput, no backpressure).
//  - Bitwise only: bit i of each output depends solely on a[i] and b[i]; no carries, no
//    cross-bit interaction, no width extension or truncation.
//  - Invariants whenever outputs are stable:
//    out_nand==~out_and, out_nor==~out_or, out_xnor==~out_xor.
//  - X/Z on inputs is not sanitized; outputs follow standard Verilog bitwise semantics.
//  - No combinational path from inputs to outputs.
// TESTING
//  - Reset: hold rst_n=0 for 2 edges with a=b=all-1, in_valid=1 -> all outputs 0, out_valid=0.
//  - WIDTH=1 truth table, in_valid=1, one vector per cycle; check each pair one edge later:
//    a=0,b=0 -> AND0 OR0 NAND1 NOR1 NOT1 XOR0 XNOR1
//    a=0,b=1 -> AND0 OR1 NAND1 NOR0 NOT1 XOR1 XNOR0
//    a=1,b=0 -> AND0 OR1 NAND1 NOR0 NOT0 XOR1 XNOR0
//    a=1,b=1 -> AND1 OR1 NAND0 NOR0 NOT0 XOR0 XNOR1
//  - Hold: capture a=1,b=0, then drop in_valid with a=b=0 -> outputs keep the a=1,b=0 values;
//    out_valid falls to 0.
//  - WIDTH=8: a=8'hA5,b=8'h0F -> AND 05, OR AF, NAND FA, NOR 50, NOT 5A, XOR AA, XNOR 55.
//  - Reset mid-stream: capture a=b=1, then assert rst_n=0 for one edge with new inputs ->
//    all outputs 0, out_valid 0; after release, the next in_valid edge resumes normally.
//  - Random: 1000 cycles random a/b/in_valid -> compare against 1-cycle-delayed bitwise model.

Source files
------------

// File: rtl/data_basic_gates_if.sv
// Operand/result bundle for the data_basic_gates logic bank.
// The producer drives operands through the master modport; the gate bank drives results through slave.
interface data_basic_gates_if #(
   parameter int WIDTH = 1
);
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             in_valid;
   logic [WIDTH-1:0] out_and;
   logic [WIDTH-1:0] out_or;
   logic [WIDTH-1:0] out_nand;
   logic [WIDTH-1:0] out_nor;
   logic [WIDTH-1:0] out_not;
   logic [WIDTH-1:0] out_xor;
   logic [WIDTH-1:0] out_xnor;
   logic             out_valid;

   modport master (
      output a, b, in_valid,
      input  out_and, out_or, out_nand, out_nor, out_not, out_xor, out_xnor, out_valid
   );

   modport slave (
      input  a, b, in_valid,
      output out_and, out_or, out_nand, out_nor, out_not, out_xor, out_xnor, out_valid
   );
endinterface

// File: rtl/data_basic_gates.sv
// Registered bank of the seven basic bitwise logic functions of a and b.
// All results and out_valid appear one clock after the operands are sampled.
module data_basic_gates #(
   parameter int WIDTH = 1
) (
   input logic               clk,
   input logic               rst_n,
   data_basic_gates_if.slave bus
);

   typedef struct packed {
      logic [WIDTH-1:0] and_v;
      logic [WIDTH-1:0] or_v;
      logic [WIDTH-1:0] nand_v;
      logic [WIDTH-1:0] nor_v;
      logic [WIDTH-1:0] not_v;
      logic [WIDTH-1:0] xor_v;
      logic [WIDTH-1:0] xnor_v;
   } gate_res_t;

   function automatic gate_res_t gate_bank(input logic [WIDTH-1:0] a,
                                           input logic [WIDTH-1:0] b);
      gate_res_t r;
      r.and_v  = a & b;
      r.or_v   = a | b;
      r.nand_v = ~(a & b);
      r.nor_v  = ~(a | b);
      r.not_v  = ~a;
      r.xor_v  = a ^ b;
      r.xnor_v = ~(a ^ b);
      return r;
   endfunction

   gate_res_t res_p0;
   gate_res_t res_p1;
   logic      vld_p1;

   // Stage p0: combinational evaluation of the operands presented this cycle
   always_comb begin
      res_p0 = gate_bank(bus.a, bus.b);
   end

   // Stage p1: capture; reset overrides a concurrent in_valid, idle cycles hold results
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         res_p1 <= '0;
         vld_p1 <= 1'b0;
      end else begin
         vld_p1 <= bus.in_valid;
         if (bus.in_valid) begin
            res_p1 <= res_p0;
         end
      end
   end

   assign bus.out_and   = res_p1.and_v;
   assign bus.out_or    = res_p1.or_v;
   assign bus.out_nand  = res_p1.nand_v;
   assign bus.out_nor   = res_p1.nor_v;
   assign bus.out_not   = res_p1.not_v;
   assign bus.out_xor   = res_p1.xor_v;
   assign bus.out_xnor  = res_p1.xnor_v;
   assign bus.out_valid = vld_p1;

endmodule

// File: tb/tb_data_basic_gates.sv
// Bench for data_basic_gates: WIDTH=1 and WIDTH=8 instances against a per-bit truth model.
module tb_data_basic_gates;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;

   data_basic_gates_if #(.WIDTH(1)) bus1 ();
   data_basic_gates_if #(.WIDTH(8)) bus8 ();

   data_basic_gates #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));
   data_basic_gates #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8.slave));

   int checks   = 0;
   int failures = 0;

   // Reference state: expected outputs indexed and,or,nand,nor,not,xor,xnor
   logic [7:0] exp8 [7];
   logic       exp1 [7];
   logic       expv8;
   logic       expv1;
   string      gname [7] = '{"and", "or", "nand", "nor", "not", "xor", "xnor"};

   // Each result bit is decided by how many of a[i], b[i] are set
   function automatic logic [7:0] gate_ref(input int k, input logic [7:0] a, input logic [7:0] b);
      logic [7:0] r;
      int ones;
      r = '0;
      for (int i = 0; i < 8; i++) begin
         ones = 0;
         if (a[i]) ones++;
         if (b[i]) ones++;
         case (k)
            0:       r[i] = (ones == 2);
            1:       r[i] = (ones >= 1);
            2:       r[i] = (ones != 2);
            3:       r[i] = (ones == 0);
            4:       r[i] = !a[i];
            5:       r[i] = (ones == 1);
            default: r[i] = (ones != 1);
         endcase
      end
      return r;
   endfunction

   function automatic logic [7:0] dut8_out(input int k);
      case (k)
         0:       return bus8.out_and;
         1:       return bus8.out_or;
         2:       return bus8.out_nand;
         3:       return bus8.out_nor;
         4:       return bus8.out_not;
         5:       return bus8.out_xor;
         default: return bus8.out_xnor;
      endcase
   endfunction

   function automatic logic dut1_out(input int k);
      case (k)
         0:       return bus1.out_and[0];
         1:       return bus1.out_or[0];
         2:       return bus1.out_nand[0];
         3:       return bus1.out_nor[0];
         4:       return bus1.out_not[0];
         5:       return bus1.out_xor[0];
         default: return bus1.out_xnor[0];
      endcase
   endfunction

   // One rising edge: advance the model from the inputs seen at that edge, then settle to negedge
   task automatic cycle();
      logic [7:0] t;
      @(posedge clk);
      if (!rst_n) begin
         for (int k = 0; k < 7; k++) begin
            exp8[k] = '0;
            exp1[k] = 1'b0;
         end
         expv8 = 1'b0;
         expv1 = 1'b0;
      end else begin
         expv8 = bus8.in_valid;
         expv1 = bus1.in_valid;
         for (int k = 0; k < 7; k++) begin
            if (bus8.in_valid) exp8[k] = gate_ref(k, bus8.a, bus8.b);
            if (bus1.in_valid) begin
               t = gate_ref(k, {7'b0, bus1.a}, {7'b0, bus1.b});
               exp1[k] = t[0];
            end
         end
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus1.a = 1'b1; bus1.b = 1'b1; bus1.in_valid = 1'b1;
      bus8.a = 8'hFF; bus8.b = 8'hFF; bus8.in_valid = 1'b1;
      cycle();
      cycle();
      for (int k = 0; k < 7; k++) begin
         checks++;
         if (dut8_out(k) !== 8'h00) begin
            failures++;
            $display("FAIL reset_w8_%s got=%h want=00", gname[k], dut8_out(k));
         end
         checks++;
         if (dut1_out(k) !== 1'b0) begin
            failures++;
            $display("FAIL reset_w1_%s got=%b want=0", gname[k], dut1_out(k));
         end
      end
      checks++;
      if (bus8.out_valid !== 1'b0 || bus1.out_valid !== 1'b0) begin
         failures++;
         $display("FAIL reset_valid got=%b%b want=00", bus1.out_valid, bus8.out_valid);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_truth_table();
      // Bits 6..0 = AND OR NAND NOR NOT XOR XNOR, rows in order ab=00,01,10,11
      logic [6:0] tt [4] = '{7'b0011101, 7'b0110110, 7'b0110010, 7'b1100001};
      bus8.in_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         bus1.a = i[1]; bus1.b = i[0]; bus1.in_valid = 1'b1;
         cycle();
         for (int k = 0; k < 7; k++) begin
            checks++;
            if (dut1_out(k) !== tt[i][6-k]) begin
               failures++;
               $display("FAIL truth_ab%0d%0d_%s got=%b want=%b", i[1], i[0], gname[k],
                        dut1_out(k), tt[i][6-k]);
            end
         end
         checks++;
         if (bus1.out_valid !== 1'b1) begin
            failures++;
            $display("FAIL truth_valid got=%b want=1", bus1.out_valid);
         end
      end
   endtask

   task automatic test_hold();
      logic [6:0] want = 7'b0110010;
      bus1.a = 1'b1; bus1.b = 1'b0; bus1.in_valid = 1'b1;
      cycle();
      bus1.a = 1'b0; bus1.b = 1'b0; bus1.in_valid = 1'b0;
      cycle();
      for (int k = 0; k < 7; k++) begin
         checks++;
         if (dut1_out(k) !== want[6-k]) begin
            failures++;
            $display("FAIL hold_%s got=%b want=%b", gname[k], dut1_out(k), want[6-k]);
         end
      end
      checks++;
      if (bus1.out_valid !== 1'b0) begin
         failures++;
         $display("FAIL hold_valid got=%b want=0", bus1.out_valid);
      end
   endtask

   task automatic test_width8();
      logic [7:0] want [7] = '{8'h05, 8'hAF, 8'hFA, 8'h50, 8'h5A, 8'hAA, 8'h55};
      bus8.a = 8'hA5; bus8.b = 8'h0F; bus8.in_valid = 1'b1;
      cycle();
      for (int k = 0; k < 7; k++) begin
         checks++;
         if (dut8_out(k) !== want[k]) begin
            failures++;
            $display("FAIL w8_%s got=%h want=%h", gname[k], dut8_out(k), want[k]);
         end
      end
      checks++;
      if (bus8.out_valid !== 1'b1) begin
         failures++;
         $display("FAIL w8_valid got=%b want=1", bus8.out_valid);
      end
   endtask

   task automatic test_reset_mid();
      bus1.a = 1'b1; bus1.b = 1'b1; bus1.in_valid = 1'b1;
      bus8.a = 8'h01; bus8.b = 8'h01; bus8.in_valid = 1'b1;
      cycle();
      rst_n = 1'b0;
      bus1.a = 1'b0; bus1.b = 1'b1;
      bus8.a = 8'h3C; bus8.b = 8'h96;
      cycle();
      for (int k = 0; k < 7; k++) begin
         checks++;
         if (dut8_out(k) !== 8'h00 || dut1_out(k) !== 1'b0) begin
            failures++;
            $display("FAIL midreset_%s got=%h/%b want=00/0", gname[k], dut8_out(k), dut1_out(k));
         end
      end
      checks++;
      if (bus8.out_valid !== 1'b0 || bus1.out_valid !== 1'b0) begin
         failures++;
         $display("FAIL midreset_valid got=%b%b want=00", bus1.out_valid, bus8.out_valid);
      end
      rst_n = 1'b1;
      bus8.a = 8'h3C; bus8.b = 8'hC3;
      cycle();
      for (int k = 0; k < 7; k++) begin
         checks++;
         if (dut8_out(k) !== exp8[k]) begin
            failures++;
            $display("FAIL resume_%s got=%h want=%h", gname[k], dut8_out(k), exp8[k]);
         end
      end
      checks++;
      if (bus8.out_valid !== 1'b1) begin
         failures++;
         $display("FAIL resume_valid got=%b want=1", bus8.out_valid);
      end
   endtask

   task automatic test_random();
      int bad = 0;
      for (int n = 0; n < 1000; n++) begin
         bus8.a = 8'($urandom); bus8.b = 8'($urandom); bus8.in_valid = 1'($urandom);
         bus1.a = 1'($urandom); bus1.b = 1'($urandom); bus1.in_valid = 1'($urandom);
         cycle();
         for (int k = 0; k < 7; k++) begin
            checks++;
            if (dut8_out(k) !== exp8[k]) begin
               failures++;
               if (bad++ < 10)
                  $display("FAIL rand_w8_%s cyc=%0d got=%h want=%h", gname[k], n, dut8_out(k), exp8[k]);
            end
            checks++;
            if (dut1_out(k) !== exp1[k]) begin
               failures++;
               if (bad++ < 10)
                  $display("FAIL rand_w1_%s cyc=%0d got=%b want=%b", gname[k], n, dut1_out(k), exp1[k]);
            end
         end
         checks++;
         if (bus8.out_valid !== expv8 || bus1.out_valid !== expv1) begin
            failures++;
            if (bad++ < 10)
               $display("FAIL rand_valid cyc=%0d got=%b%b want=%b%b", n,
                        bus1.out_valid, bus8.out_valid, expv1, expv8);
         end
         checks++;
         if (bus8.out_nand !== ~bus8.out_and || bus8.out_nor !== ~bus8.out_or ||
             bus8.out_xnor !== ~bus8.out_xor) begin
            failures++;
            if (bad++ < 10)
               $display("FAIL rand_invariant cyc=%0d nand=%h and=%h nor=%h or=%h xnor=%h xor=%h", n,
                        bus8.out_nand, bus8.out_and, bus8.out_nor, bus8.out_or,
                        bus8.out_xnor, bus8.out_xor);
         end
      end
   endtask

   initial begin
      rst_n = 1'b0;
      bus1.a = '0; bus1.b = '0; bus1.in_valid = 1'b0;
      bus8.a = '0; bus8.b = '0; bus8.in_valid = 1'b0;
      for (int k = 0; k < 7; k++) begin
         exp8[k] = '0;
         exp1[k] = 1'b0;
      end
      expv8 = 1'b0;
      expv1 = 1'b0;
      @(negedge clk);
      test_reset();
      test_truth_table();
      test_hold();
      test_width8();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
